dcache_wt: RTL

//   Blocking, direct-mapped, write-through / no-write-allocate data cache between the

---
 rtl/dcache_wt.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/dcache_wt.sv
// dcache_wt: blocking, direct-mapped, write-through / no-write-allocate data cache.
// Read hits complete in the LOOKUP cycle without stalling the core; read misses
// fetch a whole line from memory; every store is forwarded to memory as a word
// write, and a store that hits also patches the cached copy.
module dcache_wt #(
    parameter int LINES     = 16,
    parameter int LINE_BITS = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          cpu_addr,
    input  logic                 cpu_re,
    input  logic [3:0]           cpu_we,
    input  logic [31:0]          cpu_din,
    output logic [31:0]          cpu_dout,
    output logic                 stall,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic                 mem_req_rw,
    output logic [31:0]          mem_req_addr,
    output logic [31:0]          mem_req_wdata,
    output logic [3:0]           mem_req_wmask,
    input  logic                 mem_resp_valid,
    input  logic [LINE_BITS-1:0] mem_resp_data
);

    localparam int IDX      = $clog2(LINES);
    localparam int TAG_BITS = 28 - IDX;
    localparam int WORDS    = LINE_BITS / 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOOKUP  = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        WR_REQ  = 3'd4
    } state_t;

    state_t                state_r;
    state_t                state_nx_s;

    logic [31:2]           req_addr_r;
    logic [3:0]            req_we_r;
    logic [31:0]           req_din_r;
    logic [31:0]           dout_r;

    logic [LINES-1:0]      valid_r;
    logic [TAG_BITS-1:0]   tag_r  [LINES];
    logic [LINE_BITS-1:0]  data_r [LINES];

    logic [IDX-1:0]        req_idx_s;
    logic [TAG_BITS-1:0]   req_tag_s;
    logic                  hit_s;
    logic                  is_store_s;
    logic                  rd_hit_s;
    logic                  wr_hit_s;
    logic                  refill_s;
    logic                  accept_s;
    logic                  stall_s;
    logic [31:0]           hit_word_s;
    logic [LINE_BITS-1:0]  merged_line_s;
    logic                  unused_s;

    // Pick one 32-bit word out of a line.
    function automatic logic [31:0] word_sel(input logic [LINE_BITS-1:0] line,
                                             input logic [1:0]           sel);
        logic [31:0] w;
        w = 32'h0000_0000;
        for (int i = 0; i < WORDS; i++) begin
            if (sel == 2'(i)) begin
                w = line[i*32 +: 32];
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

    // Overlay enabled byte lanes of new data onto an old word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = be[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
        end
        return m;
    endfunction

    assign unused_s   = ^cpu_addr[1:0];
    assign req_idx_s  = req_addr_r[4+IDX-1:4];
    assign req_tag_s  = req_addr_r[31:4+IDX];
    assign hit_s      = valid_r[req_idx_s] && (tag_r[req_idx_s] == req_tag_s);
    assign is_store_s = (req_we_r != 4'b0000);
    assign rd_hit_s   = (state_r == LOOKUP) && !is_store_s && hit_s;
    assign wr_hit_s   = (state_r == LOOKUP) && is_store_s && hit_s;
    assign refill_s   = (state_r == RD_WAIT) && mem_resp_valid;
    assign hit_word_s = word_sel(data_r[req_idx_s], req_addr_r[3:2]);
    assign accept_s   = !stall_s && (cpu_re || (cpu_we != 4'b0000));
    assign stall      = stall_s;
    assign cpu_dout   = rd_hit_s ? hit_word_s : dout_r;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nx_s = LOOKUP;
                else          state_nx_s = IDLE;
            end
            LOOKUP: begin
                if (is_store_s)    state_nx_s = WR_REQ;
                else if (!hit_s)   state_nx_s = RD_REQ;
                else if (accept_s) state_nx_s = LOOKUP;
                else               state_nx_s = IDLE;
            end
            RD_REQ: begin
                if (mem_req_ready) state_nx_s = RD_WAIT;
                else               state_nx_s = RD_REQ;
            end
            RD_WAIT: begin
                if (mem_resp_valid) state_nx_s = IDLE;
                else                state_nx_s = RD_WAIT;
            end
            WR_REQ: begin
                if (mem_req_ready) state_nx_s = IDLE;
                else               state_nx_s = WR_REQ;
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Outputs decoded from the state; memory fields come from the held request.
    always_comb begin
        stall_s       = 1'b1;
        mem_req_valid = 1'b0;
        mem_req_rw    = 1'b0;
        mem_req_wdata = req_din_r;
        mem_req_wmask = req_we_r;
        mem_req_addr  = {req_addr_r[31:4], 4'b0000};
        case (state_r)
            IDLE: begin
                stall_s = 1'b0;
            end
            LOOKUP: begin
                if (!is_store_s && hit_s) stall_s = 1'b0;
                else                      stall_s = 1'b1;
            end
            RD_REQ: begin
                mem_req_valid = 1'b1;
            end
            RD_WAIT: begin
                mem_req_valid = 1'b0;
            end
            WR_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                mem_req_addr  = {req_addr_r[31:2], 2'b00};
            end
            default: begin
                stall_s = 1'b1;
            end
        endcase
    end

    // Capture an accepted core request; stores take priority over loads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_addr_r <= 30'h0000_0000;
            req_we_r   <= 4'b0000;
            req_din_r  <= 32'h0000_0000;
        end else if (accept_s) begin
            req_addr_r <= cpu_addr[31:2];
            req_we_r   <= cpu_we;
            req_din_r  <= cpu_din;
        end else begin
            req_addr_r <= req_addr_r;
        end
    end

    // Load-data holding register: updated by a read hit or a refill only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_r <= 32'h0000_0000;
        end else if (rd_hit_s) begin
            dout_r <= hit_word_s;
        end else if (refill_s) begin
            dout_r <= word_sel(mem_resp_data, req_addr_r[3:2]);
        end else begin
            dout_r <= dout_r;
        end
    end

    // Valid bits: cleared by reset, set by a refill; stores never allocate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r <= {LINES{1'b0}};
        end else if (refill_s) begin
            valid_r[req_idx_s] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Cached line with the store bytes applied to the addressed word.
    always_comb begin
        merged_line_s = data_r[req_idx_s];
        for (int w = 0; w < WORDS; w++) begin
            if (req_addr_r[3:2] == 2'(w)) begin
                merged_line_s[w*32 +: 32] = merge_bytes(hit_word_s, req_din_r, req_we_r);
            end else begin
                merged_line_s[w*32 +: 32] = data_r[req_idx_s][w*32 +: 32];
            end
        end
    end

    // Tag/data storage: written by refills and store hits, never reset.
    always_ff @(posedge clk) begin
        if (refill_s) begin
            data_r[req_idx_s] <= mem_resp_data;
            tag_r[req_idx_s]  <= req_tag_s;
        end else if (wr_hit_s) begin
            data_r[req_idx_s] <= merged_line_s;
        end else begin
            data_r[req_idx_s] <= data_r[req_idx_s];
        end
    end

endmodule
